// File: rtl/mem_arbiter_if.sv
// Bundle of the CPU, video and memory-port signals around mem_arbiter.
// The arbiter takes the slave view; the requesters/RAM side takes the master view.
interface mem_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic        cpu_word;
  logic [19:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_ack;
  logic        vid_req;
  logic [19:0] vid_addr;
  logic [7:0]  vid_rdata;
  logic        vid_ack;
  logic [19:0] mem_a;
  logic [7:0]  mem_o;
  logic        mem_w;
  logic [7:0]  mem_i;

  modport slave (
    input  cpu_req, cpu_we, cpu_word, cpu_addr, cpu_wdata, vid_req, vid_addr, mem_i,
    output cpu_rdata, cpu_ack, vid_rdata, vid_ack, mem_a, mem_o, mem_w
  );

  modport master (
    output cpu_req, cpu_we, cpu_word, cpu_addr, cpu_wdata, vid_req, vid_addr, mem_i,
    input  cpu_rdata, cpu_ack, vid_rdata, vid_ack, mem_a, mem_o, mem_w
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin sharing of the 8-bit memory port between CPU byte/word accesses and video byte reads.
// A write byte takes 1 cycle, a read byte 1+MEM_LAT; requests are held until their one-cycle ack.
module mem_arbiter #(
  parameter int MEM_LAT = 1
) (
  input  logic         clk25,
  input  logic         rst,
  mem_arbiter_if.slave bus
);
  localparam logic [1:0] LAT = 2'(MEM_LAT);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT} state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_cnt, w_cnt_nxt;
  logic        r_hi_pending, r_last_vid, r_cur_vid, r_cur_hi, r_cur_we;
  logic [19:0] r_mem_a;
  logic [7:0]  r_mem_o, r_vid_rdata;
  logic        r_mem_w, r_cpu_ack, r_vid_ack;
  logic [15:0] r_cpu_rdata;

  logic        w_sample, w_done, w_final, w_arb, w_hi_nxt;
  logic        w_cpu_elig, w_vid_elig, w_gnt, w_gnt_vid;
  logic [19:0] w_cpu_a;
  logic [7:0]  w_cpu_o;

  always_ff @(posedge clk25) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_sample = (r_state == S_WAIT) && (r_cnt == 2'd1);
    w_done   = w_sample || ((r_state == S_ADDR) && r_cur_we);
    w_final  = r_cur_vid || r_cur_hi || !bus.cpu_word;
    w_arb    = (r_state == S_IDLE) || w_done;
    w_hi_nxt = r_hi_pending;
    if (w_done && !r_cur_vid) w_hi_nxt = !r_cur_hi && bus.cpu_word;
    // A requester whose last byte ends at this edge sits it out, so its still-held request is not re-granted
    w_cpu_elig = bus.cpu_req && !(w_done && !r_cur_vid && w_final);
    w_vid_elig = bus.vid_req && !(w_done && r_cur_vid);
    w_gnt      = w_arb && (w_cpu_elig || w_vid_elig);
    w_gnt_vid  = w_vid_elig && (!w_cpu_elig || !r_last_vid);
    w_cpu_a    = w_hi_nxt ? (bus.cpu_addr + 20'd1) : bus.cpu_addr;
    w_cpu_o    = w_hi_nxt ? bus.cpu_wdata[15:8] : bus.cpu_wdata[7:0];

    w_state_nxt = S_IDLE;
    w_cnt_nxt   = r_cnt;
    if (w_gnt) begin
      w_state_nxt = S_ADDR;
    end else if ((r_state == S_ADDR) && !r_cur_we) begin
      w_state_nxt = S_WAIT;
      w_cnt_nxt   = LAT;
    end else if ((r_state == S_WAIT) && !w_sample) begin
      w_state_nxt = S_WAIT;
      w_cnt_nxt   = r_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      r_hi_pending <= 1'b0;
      r_last_vid   <= 1'b0;
      r_cur_vid    <= 1'b0;
      r_cur_hi     <= 1'b0;
      r_cur_we     <= 1'b0;
      r_mem_a      <= 20'd0;
      r_mem_o      <= 8'd0;
      r_mem_w      <= 1'b0;
      r_cpu_rdata  <= 16'd0;
      r_cpu_ack    <= 1'b0;
      r_vid_rdata  <= 8'd0;
      r_vid_ack    <= 1'b0;
    end else begin
      r_mem_w      <= 1'b0;
      r_cpu_ack    <= 1'b0;
      r_vid_ack    <= 1'b0;
      r_hi_pending <= w_hi_nxt;
      if (w_done) begin
        if (r_cur_vid)    r_vid_ack <= 1'b1;
        else if (w_final) r_cpu_ack <= 1'b1;
      end
      if (w_sample) begin
        if (r_cur_vid)         r_vid_rdata       <= bus.mem_i;
        else if (r_cur_hi)     r_cpu_rdata[15:8] <= bus.mem_i;
        else if (bus.cpu_word) r_cpu_rdata[7:0]  <= bus.mem_i;
        else                   r_cpu_rdata       <= {8'h00, bus.mem_i};
      end
      if (w_gnt) begin
        r_last_vid <= w_gnt_vid;
        r_cur_vid  <= w_gnt_vid;
        r_cur_hi   <= !w_gnt_vid && w_hi_nxt;
        r_cur_we   <= !w_gnt_vid && bus.cpu_we;
        r_mem_a    <= w_gnt_vid ? bus.vid_addr : w_cpu_a;
        if (!w_gnt_vid && bus.cpu_we) begin
          r_mem_o <= w_cpu_o;
          r_mem_w <= 1'b1;
        end
      end
    end
  end

  assign bus.mem_a     = r_mem_a;
  assign bus.mem_o     = r_mem_o;
  assign bus.mem_w     = r_mem_w;
  assign bus.cpu_rdata = r_cpu_rdata;
  assign bus.cpu_ack   = r_cpu_ack;
  assign bus.vid_rdata = r_vid_rdata;
  assign bus.vid_ack   = r_vid_ack;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: reset state, a vector table of CPU accesses, hand-timed corner sequences,
// and randomized concurrent CPU/video traffic checked against a byte-addressed reference memory.
module tb_mem_arbiter;
  logic clk25 = 1'b0;
  logic rst   = 1'b1;
  always #20 clk25 = ~clk25;

  mem_arbiter_if if1 ();
  mem_arbiter_if if3 ();

  mem_arbiter #(.MEM_LAT(1)) dut1 (.clk25(clk25), .rst(rst), .bus(if1));
  mem_arbiter #(.MEM_LAT(3)) dut3 (.clk25(clk25), .rst(rst), .bus(if3));

  typedef struct {
    logic        we;
    logic        word;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t        tbl[9];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  ram  [int];
  logic [7:0]  refm [int];
  logic [27:0] wlog [$];
  int          lat;
  logic [15:0] rd;
  logic        cpu_done;
  logic [19:0] ma[0:9];
  logic        ca[0:9];
  logic        va[0:9];
  logic [15:0] crd;
  logic [7:0]  vrd;

  function automatic logic [7:0] pat(input logic [19:0] a);
    return a[7:0] ^ a[19:12] ^ 8'h5C;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [19:0] a);
    return ram.exists(int'(a)) ? ram[int'(a)] : pat(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [19:0] a);
    return refm.exists(int'(a)) ? refm[int'(a)] : pat(a);
  endfunction

  // RAM behind dut1: writes commit at the edge, read data follows the address one cycle later
  initial forever begin
    @(posedge clk25);
    if (if1.mem_w === 1'b1) begin
      ram[int'(if1.mem_a)] = if1.mem_o;
      wlog.push_back({if1.mem_a, if1.mem_o});
    end
    #1;
    if1.mem_i = ram_rd(if1.mem_a);
  end

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk25);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    if1.cpu_req = 1'b0;
    if1.vid_req = 1'b0;
    if3.cpu_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic cpu_txn(input logic we, input logic word, input logic [19:0] a, input logic [15:0] wd,
                         input int bound, output int l, output logic [15:0] r);
    logic [19:0] a1;
    a1 = a + 20'd1;
    if1.cpu_we = we; if1.cpu_word = word; if1.cpu_addr = a; if1.cpu_wdata = wd;
    if1.cpu_req = 1'b1;
    l = -1;
    r = 16'd0;
    for (int k = 1; k <= bound; k++) begin
      tick();
      if (if1.cpu_ack === 1'b1) begin
        l = k;
        r = if1.cpu_rdata;
        break;
      end
    end
    if1.cpu_req = 1'b0;
    if (we) begin
      refm[int'(a)] = wd[7:0];
      if (word) refm[int'(a1)] = wd[15:8];
    end
  endtask

  initial begin
    if1.cpu_req = 0; if1.cpu_we = 0; if1.cpu_word = 0; if1.cpu_addr = 0; if1.cpu_wdata = 0;
    if1.vid_req = 0; if1.vid_addr = 0;
    if3.cpu_req = 0; if3.cpu_we = 0; if3.cpu_word = 0; if3.cpu_addr = 0; if3.cpu_wdata = 0;
    if3.vid_req = 0; if3.vid_addr = 0; if3.mem_i = 0;
    cpu_done = 1'b0;
    ram[32'h12345] = 8'hA5;

    tbl[0] = '{1'b1, 1'b0, 20'h00010, 16'h005A, 16'h0000, 2};
    tbl[1] = '{1'b0, 1'b0, 20'h00010, 16'h0000, 16'h005A, 3};
    tbl[2] = '{1'b1, 1'b1, 20'h00020, 16'h1234, 16'h0000, 3};
    tbl[3] = '{1'b0, 1'b1, 20'h00020, 16'h0000, 16'h1234, 5};
    tbl[4] = '{1'b0, 1'b0, 20'h00021, 16'h0000, 16'h0012, 3};
    tbl[5] = '{1'b1, 1'b1, 20'hFFFFF, 16'hBEEF, 16'h0000, 3};
    tbl[6] = '{1'b0, 1'b1, 20'hFFFFF, 16'h0000, 16'hBEEF, 5};
    tbl[7] = '{1'b0, 1'b0, 20'h00000, 16'h0000, 16'h00BE, 3};
    tbl[8] = '{1'b0, 1'b0, 20'hFFFFF, 16'h0000, 16'h00EF, 3};

    do_reset();
    chk("rst_mem_a", 32'(if1.mem_a), 0);
    chk("rst_mem_o", 32'(if1.mem_o), 0);
    chk("rst_mem_w", 32'(if1.mem_w), 0);
    chk("rst_cpu_rdata", 32'(if1.cpu_rdata), 0);
    chk("rst_cpu_ack", 32'(if1.cpu_ack), 0);
    chk("rst_vid_rdata", 32'(if1.vid_rdata), 0);
    chk("rst_vid_ack", 32'(if1.vid_ack), 0);
    chk("rst3_mem_w", 32'(if3.mem_w), 0);

    // Single video byte read, MEM_LAT=1
    if1.vid_addr = 20'h12345;
    if1.vid_req  = 1'b1;
    tick();
    chk("vid_c1_mem_a", 32'(if1.mem_a), 32'h12345);
    tick();
    chk("vid_c2_ack", 32'(if1.vid_ack), 0);
    tick();
    chk("vid_c3_ack", 32'(if1.vid_ack), 1);
    chk("vid_c3_rdata", 32'(if1.vid_rdata), 32'hA5);
    if1.vid_req = 1'b0;
    tick();
    chk("vid_c4_ack_pulse", 32'(if1.vid_ack), 0);

    for (int i = 0; i < 9; i++) begin
      wlog.delete();
      cpu_txn(tbl[i].we, tbl[i].word, tbl[i].addr, tbl[i].wdata, 20, lat, rd);
      chk("tbl_latency", 32'(lat), 32'(tbl[i].exp_lat));
      if (tbl[i].we) begin
        chk("tbl_wr_count", 32'(wlog.size()), tbl[i].word ? 2 : 1);
        if (wlog.size() > 0)
          chk("tbl_wr_lo", 32'(wlog[0]), 32'({tbl[i].addr, tbl[i].wdata[7:0]}));
        if (tbl[i].word && wlog.size() > 1)
          chk("tbl_wr_hi", 32'(wlog[1]), 32'({20'(tbl[i].addr + 20'd1), tbl[i].wdata[15:8]}));
      end else begin
        chk("tbl_rdata", 32'(rd), 32'(tbl[i].exp_rd));
        chk("tbl_rd_no_mem_w", 32'(wlog.size()), 0);
      end
    end

    // CPU word read and continuous video requests from reset: video wins the first tie
    do_reset();
    if1.cpu_we = 1'b0; if1.cpu_word = 1'b1; if1.cpu_addr = 20'h00100; if1.cpu_req = 1'b1;
    if1.vid_addr = 20'h00200; if1.vid_req = 1'b1;
    crd = 16'd0;
    vrd = 8'd0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) tick();
      ma[k] = if1.mem_a;
      ca[k] = if1.cpu_ack;
      va[k] = if1.vid_ack;
      if (if1.vid_ack === 1'b1 && k == 3) vrd = if1.vid_rdata;
      if (if1.cpu_ack === 1'b1) begin
        crd = if1.cpu_rdata;
        if1.cpu_req = 1'b0;
      end
    end
    chk("rr_c1_vid_addr", 32'(ma[1]), 32'h00200);
    chk("rr_c3_cpu_lo", 32'(ma[3]), 32'h00100);
    chk("rr_c5_vid_addr", 32'(ma[5]), 32'h00200);
    chk("rr_c7_cpu_hi", 32'(ma[7]), 32'h00101);
    chk("rr_c3_vid_ack", 32'(va[3]), 1);
    chk("rr_c3_vid_rdata", 32'(vrd), 32'(ref_rd(20'h00200)));
    chk("rr_c7_vid_ack", 32'(va[7]), 1);
    chk("rr_c8_cpu_ack", 32'(ca[8]), 0);
    chk("rr_c9_cpu_ack", 32'(ca[9]), 1);
    chk("rr_cpu_rdata", 32'(crd), 32'({ref_rd(20'h00101), ref_rd(20'h00100)}));
    lat = -1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (if1.vid_ack === 1'b1) begin
        lat = k;
        break;
      end
    end
    if1.vid_req = 1'b0;
    chk("rr_third_vid_ack_latency", 32'(lat), 2);

    // Reset during the WAIT cycle of a CPU high byte
    do_reset();
    if1.cpu_we = 1'b0; if1.cpu_word = 1'b1; if1.cpu_addr = 20'h00300; if1.cpu_req = 1'b1;
    tick(); tick(); tick();
    chk("rstmid_c3_hi_addr", 32'(if1.mem_a), 32'h00301);
    tick();
    rst = 1'b1;
    if1.cpu_req = 1'b0;
    tick();
    chk("rstmid_cpu_ack", 32'(if1.cpu_ack), 0);
    chk("rstmid_mem_w", 32'(if1.mem_w), 0);
    chk("rstmid_mem_a", 32'(if1.mem_a), 0);
    chk("rstmid_cpu_rdata", 32'(if1.cpu_rdata), 0);
    rst = 1'b0;
    tick();
    chk("rstmid_no_late_ack", 32'(if1.cpu_ack), 0);
    cpu_txn(1'b0, 1'b1, 20'h00300, 16'h0000, 20, lat, rd);
    chk("rstmid_reissue_latency", 32'(lat), 5);
    chk("rstmid_reissue_rdata", 32'(rd), 32'({ref_rd(20'h00301), ref_rd(20'h00300)}));

    // MEM_LAT=3 byte read: only the data present in cycle 4 is valid
    if3.cpu_we = 1'b0; if3.cpu_word = 1'b0; if3.cpu_addr = 20'h00050; if3.cpu_req = 1'b1;
    if3.mem_i = 8'hC3;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if3.mem_i = (k == 4) ? 8'h3C : 8'hC3;
      if (k == 1) chk("lat3_c1_mem_a", 32'(if3.mem_a), 32'h00050);
      if (k == 4) chk("lat3_c4_ack", 32'(if3.cpu_ack), 0);
      if (k == 5) begin
        chk("lat3_c5_ack", 32'(if3.cpu_ack), 1);
        chk("lat3_c5_rdata", 32'(if3.cpu_rdata), 32'h003C);
        if3.cpu_req = 1'b0;
      end
      if (k == 6) chk("lat3_c6_ack_pulse", 32'(if3.cpu_ack), 0);
    end

    // Randomized concurrent traffic; latency bounds express the two-way round-robin guarantee
    fork
      begin
        logic        rwe, rword;
        logic [19:0] ra;
        logic [15:0] rwd, rexp;
        int          rlat;
        logic [15:0] rrd;
        for (int i = 0; i < 200; i++) begin
          repeat ($urandom_range(0, 3)) tick();
          rwe   = 1'($urandom);
          rword = 1'($urandom);
          ra    = ($urandom_range(0, 7) == 0) ? 20'hFFFFF : 20'h00400 + 20'($urandom_range(0, 15));
          rwd   = 16'($urandom);
          rexp  = rword ? {ref_rd(ra + 20'd1), ref_rd(ra)} : {8'h00, ref_rd(ra)};
          cpu_txn(rwe, rword, ra, rwd, 9, rlat, rrd);
          chk("rnd_cpu_ack_within_9", 32'(rlat >= 1), 1);
          if (!rwe && rlat >= 1) chk("rnd_cpu_rdata", 32'(rrd), 32'(rexp));
        end
        cpu_done = 1'b1;
      end
      begin
        logic [19:0] vaddr;
        logic [7:0]  vdat;
        int          vlat;
        while (!cpu_done) begin
          repeat ($urandom_range(0, 2)) tick();
          vaddr = 20'h00800 + 20'($urandom_range(0, 255));
          if1.vid_addr = vaddr;
          if1.vid_req  = 1'b1;
          vlat = -1;
          vdat = 8'd0;
          for (int k = 1; k <= 5; k++) begin
            tick();
            if (if1.vid_ack === 1'b1) begin
              vlat = k;
              vdat = if1.vid_rdata;
              break;
            end
          end
          if1.vid_req = 1'b0;
          chk("rnd_vid_ack_within_5", 32'(vlat >= 1), 1);
          if (vlat >= 1) chk("rnd_vid_rdata", 32'(vdat), 32'(ref_rd(vaddr)));
        end
      end
    join

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
